// File: rtl/bitrev_pkg.sv
// Shared constants, types and the bit-reversal helper for the swap scheduler.
package bitrev_pkg;

  localparam int unsigned D_WIDTH  = 16;
  localparam int unsigned RADIX_K1 = 2;
  localparam int unsigned L_WIDTH  = 4;

  localparam int unsigned IDX_BITS = $clog2(D_WIDTH);
  // Wide enough for RADIX_K1*l without truncation and for comparing against D_WIDTH.
  localparam int unsigned W_BITS =
    ((IDX_BITS + 1) > (L_WIDTH + $clog2(RADIX_K1) + 1)) ?
    (IDX_BITS + 1) : (L_WIDTH + $clog2(RADIX_K1) + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               keep;
    logic [D_WIDTH-1:0] idx;
    logic [D_WIDTH-1:0] rev;
  } stage1_t;

  // Reverse bits [w-1:0] of idx; bits at or above w come out as zero.
  function automatic logic [D_WIDTH-1:0] bit_reverse(input logic [D_WIDTH-1:0] idx,
                                                     input logic [W_BITS-1:0]  w);
    logic [D_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < D_WIDTH; i++) begin
      if (i < 32'(w)) begin
        r[i] = idx[IDX_BITS'(32'(w) - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_swap_scheduler_pipe.sv
// Single registered reversal stage: captures {idx, rev(idx), keep} when enabled.
module bitrev_pipe
  import bitrev_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [D_WIDTH-1:0]  idx,
  input  logic [W_BITS-1:0]   w,
  output stage1_t             s1
);

  logic [D_WIDTH-1:0] rev;
  logic               keep;

  // Reversal and swap-direction test for the index currently presented.
  always_comb begin
    rev  = bit_reverse(idx, w);
    keep = in_valid && (rev > idx);
  end

  // Stage register; holds while the downstream pair is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (en) begin
      s1.valid <= in_valid;
      s1.keep  <= keep;
      s1.idx   <= idx;
      s1.rev   <= rev;
    end
  end

endmodule

// File: rtl/bitrev_swap_scheduler.sv
// Walks all indices of a 2^W transform and issues each bit-reversal swap pair once.
module bitrev_swap_scheduler
  import bitrev_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [L_WIDTH-1:0] l,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               swap_valid,
  input  logic               swap_ready,
  output logic [D_WIDTH-1:0] swap_addr_a,
  output logic [D_WIDTH-1:0] swap_addr_b,
  output logic [D_WIDTH-1:0] swap_count
);

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] idx_q, idx_d;
  logic [W_BITS-1:0]  w_q, w_d;
  logic [D_WIDTH-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [W_BITS-1:0]  w_calc;
  logic               w_bad;
  logic [D_WIDTH:0]   span_m1;
  logic [D_WIDTH-1:0] last_idx;
  logic               stall;
  logic               in_valid;
  stage1_t            s1;

  bitrev_pipe u_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (!stall),
    .in_valid (in_valid),
    .idx      (idx_q),
    .w        (w_q),
    .s1       (s1)
  );

  // Handshake view of stage1 and job-size decode.
  always_comb begin
    swap_valid  = s1.valid && s1.keep;
    swap_addr_a = s1.idx;
    swap_addr_b = s1.rev;
    stall       = swap_valid && !swap_ready;
    w_calc      = W_BITS'(RADIX_K1) * W_BITS'(l);
    w_bad       = (w_calc == '0) || (w_calc > W_BITS'(D_WIDTH));
    // 17-bit span so W == D_WIDTH still yields an all-ones last index.
    span_m1     = ((D_WIDTH + 1)'(1) << w_q) - (D_WIDTH + 1)'(1);
    last_idx    = span_m1[D_WIDTH-1:0];
    busy        = (state_q == RUN) || (state_q == DRAIN);
    done        = (state_q == FIN);
    err         = err_q;
    swap_count  = cnt_q;
  end

  // Next-state, index walk and pair counting.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    in_valid = 1'b0;
    if (swap_valid && swap_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d   = w_calc;
          cnt_d = '0;
          if (w_bad) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        in_valid = 1'b1;
        if (!stall) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == last_idx) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and job registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bitrev_swap_scheduler.sv
// Scoreboard bench: main process queues expected pairs, monitor checks each accepted pair.
module tb_bitrev_swap_scheduler;
  import bitrev_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [L_WIDTH-1:0] l = '0;
  logic               busy, done, err, swap_valid;
  logic               swap_ready = 1'b1;
  logic [D_WIDTH-1:0] swap_addr_a, swap_addr_b, swap_count;

  int vectors = 0;
  int miscompares = 0;
  int acc_cnt = 0;
  int ready_mode = 0;
  logic [31:0] exp_q[$];

  bitrev_swap_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .l           (l),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .swap_valid  (swap_valid),
    .swap_ready  (swap_ready),
    .swap_addr_a (swap_addr_a),
    .swap_addr_b (swap_addr_b),
    .swap_count  (swap_count)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_pair(int a, int b);
    exp_q.push_back({a[15:0], b[15:0]});
  endfunction

  // Ready pattern 1,0,0,1 when mode is set, else always ready.
  initial begin
    int pi = 0;
    logic [3:0] pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode != 0) begin
        swap_ready = pat[pi];
        pi = (pi + 1) % 4;
      end else begin
        swap_ready = 1'b1;
      end
    end
  end

  // Monitor: compare accepted pairs against the queue and check stall stability.
  initial begin
    logic               prev_stall = 1'b0;
    logic [D_WIDTH-1:0] prev_a = '0, prev_b = '0;
    logic [31:0]        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", {swap_valid, swap_addr_a, swap_addr_b}, {1'b1, prev_a, prev_b});
        end
        if (swap_valid && swap_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pair", {swap_addr_a, swap_addr_b}, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("pair", {swap_addr_a, swap_addr_b}, e);
          end
          acc_cnt++;
        end
        prev_stall = swap_valid && !swap_ready;
        prev_a = swap_addr_a;
        prev_b = swap_addr_b;
      end
    end
  end

  task automatic pulse_start(input logic [L_WIDTH-1:0] lv);
    @(posedge clk);
    #1;
    l = lv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err, input int exp_cnt, input int max_lat);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    if (seen) begin
      check("done_latency_ok", (n <= max_lat), 1'b1);
      check("err", err, exp_err);
      check("swap_count", swap_count, exp_cnt);
      check("busy_at_done", busy, 1'b0);
      check("pairs_left", exp_q.size(), 0);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
    end
  endtask

  initial begin
    int target, n;
    // Reset state.
    @(negedge clk);
    check("reset_outputs", {busy, done, err, swap_valid, swap_addr_a, swap_addr_b, swap_count}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Rejected jobs: W=0 and W=18.
    pulse_start(4'd0);
    wait_done(1'b1, 0, 2);
    pulse_start(4'd9);
    wait_done(1'b1, 0, 2);

    // W=2, always ready.
    push_pair(1, 2);
    pulse_start(4'd1);
    wait_done(1'b0, 1, 400);

    // W=4, always ready.
    push_pair(1, 8); push_pair(2, 4); push_pair(3, 12);
    push_pair(5, 10); push_pair(7, 14); push_pair(11, 13);
    pulse_start(4'd2);
    wait_done(1'b0, 6, 400);

    // W=4 with stalls.
    ready_mode = 1;
    push_pair(1, 8); push_pair(2, 4); push_pair(3, 12);
    push_pair(5, 10); push_pair(7, 14); push_pair(11, 13);
    pulse_start(4'd2);
    wait_done(1'b0, 6, 400);
    ready_mode = 0;

    // Second start during RUN must be ignored.
    push_pair(1, 8); push_pair(2, 4); push_pair(3, 12);
    push_pair(5, 10); push_pair(7, 14); push_pair(11, 13);
    pulse_start(4'd2);
    @(negedge clk);
    check("busy_running", busy, 1'b1);
    pulse_start(4'd1);
    wait_done(1'b0, 6, 400);

    // Reset after three accepted pairs aborts the job.
    push_pair(1, 8); push_pair(2, 4); push_pair(3, 12);
    push_pair(5, 10); push_pair(7, 14); push_pair(11, 13);
    target = acc_cnt + 3;
    pulse_start(4'd2);
    n = 0;
    while (acc_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("three_pairs_before_rst", (acc_cnt >= target), 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("outputs_in_rst", {busy, done, err, swap_valid, swap_addr_a, swap_addr_b, swap_count}, '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("no_done_after_abort", {done, busy}, 2'b00);

    push_pair(1, 2);
    pulse_start(4'd1);
    wait_done(1'b0, 1, 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitrev_swap_scheduler.md
Name: bitrev_swap_scheduler

Overview:
- Sequences the in-place bit-reversal permutation of an NTT coefficient memory ahead of the first NWC butterfly stage.
- Walks every index of a 2^(RADIX_K1*l)-point transform and computes its bit-reversed partner through a one-stage registered reversal pipe.
- Emits each swap pair exactly once (only where rev > idx) to the memory-swap engine over a valid/ready handshake.
- Sits between the top-level NTT controller (start/done) and the coefficient-memory swap engine.

Parameters:
- D_WIDTH, 16, index/address width in bits.
- RADIX_K1, 2, log2 of the radix; reversal width W = RADIX_K1*l.
- L_WIDTH, 4, width of the stage-count input l.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse; samples l when idle
- l  input  L_WIDTH  number of radix stages; W = RADIX_K1*l
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at end of job (including rejected jobs)
- err  output  1  valid with done; 1 = job rejected (W==0 or W>D_WIDTH)
- swap_valid  output  1  swap pair presented
- swap_ready  input  1  swap engine accepts pair
- swap_addr_a  output  D_WIDTH  lower address of pair (idx)
- swap_addr_b  output  D_WIDTH  higher address of pair (rev(idx))
- swap_count  output  D_WIDTH  number of pairs accepted in current/last job

Behaviour:
- Reset values: busy=0, done=0, err=0, swap_valid=0, swap_addr_a=0, swap_addr_b=0, swap_count=0; FSM=IDLE; counter and pipe cleared. Reset mid-job aborts the job with no done pulse.
- W is computed once at start as RADIX_K1*l, zero-extended to at least log2(D_WIDTH)+1 bits before the multiply (no truncation). Latched W is held for the whole job.
- rev(idx) reverses bits [W-1:0] of idx; bits [D_WIDTH-1:W] of the result are 0.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: on start, if W==0 or W>D_WIDTH, go to FIN with err=1. Otherwise clear idx, swap_count and err, then go to RUN. start while not IDLE is ignored.
  - RUN: each non-stalled cycle, stage0 presents idx, and the stage1 register captures {idx, rev(idx), keep = rev>idx}. idx increments. When idx == 2^W-1 has been issued, go to DRAIN.
  - DRAIN: wait until stage1 is empty or its pair is accepted, then go to FIN.
  - FIN: done=1 for exactly one cycle, then return to IDLE. busy=0 from FIN onward.
- Output: swap_valid = stage1 valid && keep. Entries with keep=0 are discarded from stage1 without a handshake, at one per cycle.
- Stall: when swap_valid && !swap_ready, stage1 holds, idx holds, and swap_addr_a/b stay stable. swap_valid must not drop until the pair is accepted.
- Throughput: one index per cycle. Latency from start to first possible swap_valid is 2 cycles.
- swap_count increments on each swap_valid && swap_ready. Expected final count = (2^W - 2^ceil(W/2)) / 2.
- swap_ready is ignored while swap_valid=0.
- A start arriving in the same cycle as done is ignored.

Decomposition:
- Package bitrev_pkg:
  - constants D_WIDTH, RADIX_K1, L_WIDTH
  - FSM state enum
  - stage1 struct {valid, keep, idx, rev}
  - function bit_reverse(idx, w)
- Sub-module bitrev_pipe: the single registered reversal stage with enable/stall.
- The FSM, counter and handshake stay in bitrev_swap_scheduler.

Test Plan:
- l=1 (W=2), swap_ready=1 -> exactly one pair (1,2); done pulses once; swap_count=1; err=0.
- l=2 (W=4), swap_ready=1 -> pairs (1,8),(2,4),(3,12),(5,10),(7,14),(11,13) in that order; swap_count=6.
- l=2 with swap_ready toggling 1,0,0,1 pseudo-randomly -> same 6 pairs in the same order; addresses stable during every stall; no duplicates or drops.
- l=0, and l=9 with D_WIDTH=16 -> done with err=1 two cycles after start; swap_valid never asserted; swap_count=0.
- start pulsed again during RUN with l=2 -> ignored; job completes with W=4 results only.
- rst asserted mid-job after 3 pairs, then start with l=1 -> all outputs at reset values during rst; new job yields only (1,2) and swap_count=1.
